bin_to_bcd_seq: RTL and testbench

//  Iterative (shift-add-3 / double-dabble) binary-to-BCD converter. Turns an

---
 rtl/bin_to_bcd_seq.sv | 79 +++++++
 tb/tb_bin_to_bcd_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_SAT_EN to saturate inputs above 9999 to 9999 and flag ovf.
module bin_to_bcd_seq #(
   parameter int W = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] bin,
   output logic         ready,
   output logic         done_tick,
   output logic [3:0]   bcd3,
   output logic [3:0]   bcd2,
   output logic [3:0]   bcd1,
   output logic [3:0]   bcd0,
   output logic         ovf
);
   localparam int CW = $clog2(W + 1);
   typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [W-1:0] bin_sh;
   logic [15:0] bcd_w, bcd_adj, bcd_nxt;
   logic last;
   for (genvar i = 0; i < 4; i++) begin : g_adj
      assign bcd_adj[4*i+:4] = bcd_w[4*i+:4] >= 4'd5 ? bcd_w[4*i+:4] + 4'd3 : bcd_w[4*i+:4];
   end
   // thousands carry drops out of the top of the shift
   assign bcd_nxt = {bcd_adj[14:0], bin_sh[W-1]};
   assign last = cnt == CW'(1);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = (state == IDLE && start) ? OP :
                (state == OP && last)    ? DONE :
                (state == DONE)          ? IDLE : state;
   end
   always_comb begin
      ready = state == IDLE;
      done_tick = state == DONE;
   end
`ifdef BIN2BCD_SAT_EN
   logic sat;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sat <= 1'b0;
         ovf <= 1'b0;
      end else if (state == IDLE && start) begin
         sat <= 32'(bin) > 32'd9999;
      end else if (state == OP && last) begin
         ovf <= sat;
      end
`else
   logic [15:0] unused_sat;
   assign unused_sat = 16'h0;
   assign ovf = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bin_sh <= '0;
         bcd_w <= '0;
         cnt <= '0;
         {bcd3, bcd2, bcd1, bcd0} <= '0;
      end else if (state == IDLE && start) begin
         bin_sh <= bin;
         bcd_w <= '0;
         cnt <= CW'(W);
      end else if (state == OP) begin
         bin_sh <= bin_sh << 1;
         bcd_w <= bcd_nxt;
         cnt <= cnt - CW'(1);
`ifdef BIN2BCD_SAT_EN
         if (last) {bcd3, bcd2, bcd1, bcd0} <= sat ? 16'h9999 : bcd_nxt;
`else
         if (last) {bcd3, bcd2, bcd1, bcd0} <= bcd_nxt;
`endif
      end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of bin_to_bcd_seq (W=14) latency, handshake and results.
module tb_bin_to_bcd_seq;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [13:0] bin = '0;
   logic ready, done_tick, ovf;
   logic [3:0] bcd3, bcd2, bcd1, bcd0;
   int passed = 0, total = 0;
   bin_to_bcd_seq #(.W(14)) dut (
      .clk(clk), .rst(rst), .start(start), .bin(bin), .ready(ready),
      .done_tick(done_tick), .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1),
      .bcd0(bcd0), .ovf(ovf)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   function automatic logic [15:0] digits();
      return {bcd3, bcd2, bcd1, bcd0};
   endfunction
   // start at edge k; done_tick must be seen high after edge k+14 only
   task automatic wait_done(input string tag, input logic [15:0] e, input logic eo);
      int n = 0;
      while (!done_tick && n < 20) begin
         @(negedge clk);
         n++;
         if (n < 14) chk({tag, "_busy"}, ready, 0);
      end
      chk({tag, "_lat"}, n, 14);
      chk({tag, "_dig"}, digits(), e);
      chk({tag, "_ovf"}, ovf, eo);
      @(negedge clk);
      chk({tag, "_pulse"}, done_tick, 0);
      chk({tag, "_rdy"}, ready, 1);
   endtask
   task automatic run(input string tag, input logic [13:0] v, input logic [15:0] e, input logic eo);
      @(negedge clk);
      start = 1'b1;
      bin = v;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_acc"}, ready, 0);
      wait_done(tag, e, eo);
   endtask
   initial begin
      int dones;
      logic sat;
`ifdef BIN2BCD_SAT_EN
      sat = 1'b1;
`else
      sat = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rdy", ready, 1);
      chk("rst_done", done_tick, 0);
      chk("rst_dig", digits(), 16'h0000);
      chk("rst_ovf", ovf, 0);
      run("c1234", 14'd1234, 16'h1234, 0);
      @(negedge clk);
      chk("hold_dig", digits(), 16'h1234);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_rst_rdy", ready, 1);
      chk("idle_rst_dig", digits(), 16'h0000);
      chk("idle_rst_done", done_tick, 0);
      // back-to-back with start held high
      start = 1'b1;
      bin = 14'd0;
      @(negedge clk);
      bin = 14'd9999;
      chk("b2b_acc", ready, 0);
      wait_done("b2b0", 16'h0000, 0);
      chk("b2b_wait", ready, 1);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_acc2", ready, 0);
      wait_done("b2b9", 16'h9999, 0);
      run("c10000", 14'd10000, sat ? 16'h9999 : 16'h0000, sat);
      run("c16383", 14'd16383, sat ? 16'h9999 : 16'h6383, sat);
      run("c0042", 14'd42, 16'h0042, 0);
      // start and bin disturbed during OP
      @(negedge clk);
      start = 1'b1;
      bin = 14'd5678;
      @(negedge clk);
      bin = 14'd1111;
      repeat (3) @(negedge clk);
      start = 1'b0;
      bin = 14'd2222;
      dones = 0;
      repeat (30) begin
         @(negedge clk);
         if (done_tick) dones++;
      end
      chk("ign_dones", dones, 1);
      chk("ign_dig", digits(), 16'h5678);
      // reset around iteration 7 of 4321
      @(negedge clk);
      start = 1'b1;
      bin = 14'd4321;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_dig", digits(), 16'h0000);
      chk("mid_rst_rdy", ready, 1);
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_tick) dones++;
      end
      chk("mid_rst_nodone", dones, 0);
      chk("mid_rst_dig2", digits(), 16'h0000);
      run("c4321", 14'd4321, 16'h4321, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
